// File: rtl/pad_cell_output_array.sv
// Output pad bank: registered data, OE turnaround sequencing and shadowed attributes.
// Optional macro PAD_OUT_SYNC_EN adds a 2-flop synchroniser on each pad_out_o bit.

package core_v_mini_mcu_pkg;
  typedef enum logic [1:0] {TOP, RIGHT, BOTTOM, LEFT} pad_side_e;
endpackage

module pad_cell_output #(
  parameter int unsigned                  PADATTR = 16,
  parameter core_v_mini_mcu_pkg::pad_side_e SIDE  = core_v_mini_mcu_pkg::TOP
) (
  input  logic               pad_in_i,
  input  logic               pad_oe_i,
  output logic               pad_out_o,
  inout  wire                pad_io,
  input  logic [PADATTR-1:0] pad_attributes_i
);
  // Behavioural cell: drive strength and ring side only matter to the physical pad.
  logic unused_attr;
  assign unused_attr = ^{pad_attributes_i, SIDE};
  assign pad_io      = pad_oe_i ? pad_in_i : 1'bz;
  assign pad_out_o   = pad_io;
endmodule

module pad_cell_output_array #(
  parameter int unsigned                    NUM_PADS = 8,
  parameter int unsigned                    PADATTR  = 16,
  parameter int unsigned                    OE_DELAY = 4,
  parameter logic [PADATTR-1:0]             ATTR_RST = '0,
  parameter core_v_mini_mcu_pkg::pad_side_e SIDE     = core_v_mini_mcu_pkg::TOP,
  localparam int unsigned                   SEL_W    = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM_PADS-1:0] pad_in_i,
  input  logic [NUM_PADS-1:0] pad_oe_i,
  output logic [NUM_PADS-1:0] pad_out_o,
  inout  wire  [NUM_PADS-1:0] pad_io,
  input  logic                attr_valid_i,
  output logic                attr_ready_o,
  input  logic [SEL_W-1:0]    attr_sel_i,
  input  logic [PADATTR-1:0]  attr_data_i,
  output logic                busy_o
);
  typedef enum logic [1:0] {OFF, TURN_ON, ON, TURN_OFF} state_e;

  localparam logic [7:0] CNT_LOAD = 8'(OE_DELAY - 1);

  state_e              state_q [NUM_PADS];
  state_e              state_d [NUM_PADS];
  logic [7:0]          cnt_q   [NUM_PADS];
  logic [7:0]          cnt_d   [NUM_PADS];
  logic [PADATTR-1:0]  attr_q  [NUM_PADS];
  logic [NUM_PADS-1:0] oe_q, oe_d;
  logic [NUM_PADS-1:0] data_q;
  logic [NUM_PADS-1:0] cell_out;
  logic                busy_q, busy_d;
  logic                sel_valid, attr_we;

  // NOTE: every variable gets its default first so no latch is inferred.
  always_comb begin
    busy_d = 1'b0;
    oe_d   = '0;
    for (int i = 0; i < NUM_PADS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        OFF: begin
          if (pad_oe_i[i]) begin
            state_d[i] = TURN_ON;
            cnt_d[i]   = CNT_LOAD;
          end
        end
        TURN_ON: begin
          if (!pad_oe_i[i])          state_d[i] = OFF;
          else if (cnt_q[i] == 8'd0) state_d[i] = ON;
          else                       cnt_d[i]   = cnt_q[i] - 8'd1;
        end
        ON: begin
          if (!pad_oe_i[i]) begin
            state_d[i] = TURN_OFF;
            cnt_d[i]   = CNT_LOAD;
          end
        end
        TURN_OFF: begin
          // The request is ignored until the full release gap has elapsed.
          if (cnt_q[i] != 8'd0) begin
            cnt_d[i] = cnt_q[i] - 8'd1;
          end else if (pad_oe_i[i]) begin
            state_d[i] = TURN_ON;
            cnt_d[i]   = CNT_LOAD;
          end else begin
            state_d[i] = OFF;
          end
        end
        default: state_d[i] = OFF;
      endcase
      oe_d[i] = (state_d[i] == ON);
      busy_d  = busy_d | (state_d[i] == TURN_ON) | (state_d[i] == TURN_OFF);
    end
  end

  // Out-of-range selects are accepted and silently dropped.
  assign sel_valid    = 32'(attr_sel_i) < NUM_PADS;
  assign attr_ready_o = !sel_valid || (state_q[attr_sel_i] == OFF);
  assign attr_we      = attr_valid_i && attr_ready_o && sel_valid;

  // NOTE: attribute shadows are reset because the cells must see ATTR_RST straight after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_PADS; i++) begin
        state_q[i] <= OFF;
        cnt_q[i]   <= '0;
        attr_q[i]  <= ATTR_RST;
      end
      oe_q   <= '0;
      data_q <= '0;
      busy_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_PADS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        if (attr_we && (attr_sel_i == SEL_W'(i))) attr_q[i] <= attr_data_i;
      end
      oe_q   <= oe_d;
      data_q <= pad_in_i;
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

  for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
    pad_cell_output #(
      .PADATTR (PADATTR),
      .SIDE    (SIDE)
    ) u_cell (
      .pad_in_i         (data_q[i]),
      .pad_oe_i         (oe_q[i]),
      .pad_out_o        (cell_out[i]),
      .pad_io           (pad_io[i]),
      .pad_attributes_i (attr_q[i])
    );
  end

`ifdef PAD_OUT_SYNC_EN
  logic [NUM_PADS-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= cell_out;
      sync2_q <= sync1_q;
    end
  end

  assign pad_out_o = sync2_q;
`else
  assign pad_out_o = cell_out;
`endif

endmodule
